// File: rtl/dsp_simd_pack_i8.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_simd_pack_i8
//  Description : Operand packer for the DSP bitwise datapath. Collects a
//                stream of DW-bit operand pairs and packs them, one pair per
//                lane, into LANES x LANE_W SIMD words. A word is emitted
//                after LANES accepted beats, or earlier when a beat carries
//                in_last. Both sides use valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   1              rising-edge clock
//    reset      in   1              asynchronous active-high reset
//    in_valid   in   1              input beat valid
//    in_ready   out  1              block accepts the input beat
//    in_a       in   DW             operand A for the current lane
//    in_b       in   DW             operand B for the current lane
//    in_last    in   1              this beat closes the word regardless of fill
//    out_valid  out  1              packed word valid
//    out_ready  in   1              consumer accepts the packed word
//    out_a      out  LANES*LANE_W   packed A operand
//    out_b      out  LANES*LANE_W   packed B operand
//    out_mask   out  LANES          bit i set = lane i holds real data
// ============================================================================
module dsp_simd_pack_i8 #(
   parameter int LANES  = 4,
   parameter int LANE_W = 12,
   parameter int DW     = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DW-1:0]             in_a,
   input  logic [DW-1:0]             in_b,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*LANE_W-1:0]   out_a,
   output logic [LANES*LANE_W-1:0]   out_b,
   output logic [LANES-1:0]          out_mask
);

   localparam int WW = LANES * LANE_W;
   // Counter needs at least one bit even for a single-lane configuration.
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(LANES - 1);

   // FILLING: no word held. HOLDING: a word waits on out_ready.
   typedef enum logic [0:0] {
      S_FILLING = 1'b0,
      S_HOLDING = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]     acc_a_q, acc_a_d;
   logic [WW-1:0]     acc_b_q, acc_b_d;
   logic [LANES-1:0]  acc_mask_q, acc_mask_d;
   logic [WW-1:0]     out_a_q, out_a_d;
   logic [WW-1:0]     out_b_q, out_b_d;
   logic [LANES-1:0]  out_mask_q, out_mask_d;

   logic              beat_accept;
   logic              beat_close;
   logic [WW-1:0]     merged_a;
   logic [WW-1:0]     merged_b;
   logic [LANES-1:0]  merged_mask;

   // ------------------------------------------------------------------------
   // Handshake. in_ready looks at out_ready only (never at in_valid), so a
   // word being drained this cycle frees the slot for a new closing beat.
   // ------------------------------------------------------------------------
   assign in_ready    = !reset && ((state_q == S_FILLING) || out_ready);
   assign beat_accept = in_valid && in_ready;
   assign beat_close  = beat_accept && ((cnt_q == C_CNT_LAST) || in_last);

   // ------------------------------------------------------------------------
   // Accumulator with the current beat merged into lane cnt_q. Lanes not yet
   // written are zero because the accumulator is cleared on every close, so
   // the merged value is directly the outgoing word on a closing beat.
   // ------------------------------------------------------------------------
   always_comb begin
      merged_a    = acc_a_q;
      merged_b    = acc_b_q;
      merged_mask = acc_mask_q;
      for (int i = 0; i < LANES; i++) begin
         if (cnt_q == CW'(i)) begin
            // Cast zero-extends the operand into the full lane.
            merged_a[i*LANE_W +: LANE_W] = LANE_W'(in_a);
            merged_b[i*LANE_W +: LANE_W] = LANE_W'(in_b);
            merged_mask[i]               = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output-valid state: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (beat_close) begin
         // Also covers drain + close in one cycle: stay valid, no bubble.
         state_d = S_HOLDING;
      end else if ((state_q == S_HOLDING) && out_ready) begin
         state_d = S_FILLING;
      end
   end

   // ------------------------------------------------------------------------
   // Fill counter, accumulator and output word: next-state logic.
   // Output registers change only on a closing beat, so they hold steady
   // under backpressure and keep their last value after a drain.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q;
      acc_a_d    = acc_a_q;
      acc_b_d    = acc_b_q;
      acc_mask_d = acc_mask_q;
      out_a_d    = out_a_q;
      out_b_d    = out_b_q;
      out_mask_d = out_mask_q;
      if (beat_accept) begin
         if (beat_close) begin
            cnt_d      = '0;
            acc_a_d    = '0;
            acc_b_d    = '0;
            acc_mask_d = '0;
            out_a_d    = merged_a;
            out_b_d    = merged_b;
            out_mask_d = merged_mask;
         end else begin
            cnt_d      = cnt_q + 1'b1;
            acc_a_d    = merged_a;
            acc_b_d    = merged_b;
            acc_mask_d = merged_mask;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_FILLING;
         cnt_q      <= '0;
         acc_a_q    <= '0;
         acc_b_q    <= '0;
         acc_mask_q <= '0;
         out_a_q    <= '0;
         out_b_q    <= '0;
         out_mask_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_a_q    <= acc_a_d;
         acc_b_q    <= acc_b_d;
         acc_mask_q <= acc_mask_d;
         out_a_q    <= out_a_d;
         out_b_q    <= out_b_d;
         out_mask_q <= out_mask_d;
      end
   end

   assign out_valid = (state_q == S_HOLDING);
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_mask  = out_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_simd_pack_i8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_simd_pack_i8
//  Description : Self-checking bench for dsp_simd_pack_i8. Directed beats
//                with hand-computed packed words pushed into a scoreboard
//                queue; a monitor pops and compares on every output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_simd_pack_i8;

   localparam int LANES  = 4;
   localparam int LANE_W = 12;
   localparam int DW     = 8;
   localparam int WW     = LANES * LANE_W;

   typedef struct packed {
      logic [WW-1:0]    a;
      logic [WW-1:0]    b;
      logic [LANES-1:0] m;
   } word_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DW-1:0]     in_a = '0;
   logic [DW-1:0]     in_b = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WW-1:0]     out_a;
   logic [WW-1:0]     out_b;
   logic [LANES-1:0]  out_mask;

   word_t sb_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    stall_cycles = 0;

   dsp_simd_pack_i8 #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .DW     (DW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_mask  (out_mask)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [LANES-1:0] m);
      word_t w;
      w.a = a;
      w.b = b;
      w.m = m;
      sb_q.push_back(w);
   endtask

   // Present one beat and return 1 time unit after the edge that accepts it.
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
      int waited = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      @(negedge clock);
      while (!in_ready && waited < 100) begin
         waited++;
         stall_cycles++;
         @(negedge clock);
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready still 0 after %0d cycles", waited);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: every cycle that ends in a transfer consumes one expected word.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got word a=0x%0h b=0x%0h m=0x%0h, none expected",
                     out_a, out_b, out_mask);
         end else begin
            word_t e;
            e = sb_q.pop_front();
            check("sb_out_a", 64'(out_a), 64'(e.a));
            check("sb_out_b", 64'(out_b), 64'(e.b));
            check("sb_out_mask", 64'(out_mask), 64'(e.m));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b1;
      idle(2);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_a", 64'(out_a), 64'd0);
      check("rst_out_b", 64'(out_b), 64'd0);
      check("rst_out_mask", 64'(out_mask), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      idle(1);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // ---------------- full word ----------------
      out_ready = 1'b1;
      push(48'h0800FF001003, 48'h00100F002008, 4'hF);
      send(8'h03, 8'h08, 1'b0);
      send(8'h01, 8'h02, 1'b0);
      check("full_no_early_valid", 64'(out_valid), 64'd0);
      send(8'hFF, 8'h0F, 1'b0);
      send(8'h80, 8'h01, 1'b0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      idle(2);

      // ---------------- partial flush, then single-beat flush ----------------
      push(48'h000000007005, 48'h000000009006, 4'h3);
      send(8'h05, 8'h06, 1'b0);
      send(8'h07, 8'h09, 1'b1);
      check("flush_out_valid", 64'(out_valid), 64'd1);
      push(48'h000000000003, 48'h000000000008, 4'h1);
      send(8'h03, 8'h08, 1'b1);
      check("single_out_valid", 64'(out_valid), 64'd1);
      idle(2);

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      push(48'h007005003001, 48'h008006004002, 4'hF);
      send(8'h01, 8'h02, 1'b0);
      send(8'h03, 8'h04, 1'b0);
      send(8'h05, 8'h06, 1'b0);
      send(8'h07, 8'h08, 1'b0);
      in_valid = 1'b1;
      in_a     = 8'h11;
      in_b     = 8'h22;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_out_a", 64'(out_a), 64'h007005003001);
         check("bp_out_b", 64'(out_b), 64'h008006004002);
         check("bp_out_mask", 64'(out_mask), 64'hF);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      check("bp_drained_valid", 64'(out_valid), 64'd0);
      check("bp_drained_hold_a", 64'(out_a), 64'h007005003001);
      push(48'h000000000011, 48'h000000000022, 4'h1);
      send(8'h11, 8'h22, 1'b1);
      check("bp_next_valid", 64'(out_valid), 64'd1);
      idle(2);

      // ---------------- back-to-back ----------------
      stall_cycles = 0;
      push(48'h004003002001, 48'h0A40A30A20A1, 4'hF);
      push(48'h008007006005, 48'h0B80B70B60B5, 4'hF);
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] av;
         logic [7:0] bv;
         av = 8'(i);
         bv = (i <= 4) ? 8'(8'hA0 + i) : 8'(8'hB0 + i);
         send(av, bv, 1'b0);
         if (i == 4) check("b2b_valid_after_4", 64'(out_valid), 64'd1);
         if (i == 5) check("b2b_valid_after_5", 64'(out_valid), 64'd0);
         if (i == 8) check("b2b_valid_after_8", 64'(out_valid), 64'd1);
      end
      check("b2b_stalls", 64'(stall_cycles), 64'd0);
      idle(2);

      // ---------------- reset mid-word ----------------
      send(8'hAA, 8'hBB, 1'b0);
      send(8'hCC, 8'hDD, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      check("amid_rst_out_valid", 64'(out_valid), 64'd0);
      check("amid_rst_out_a", 64'(out_a), 64'd0);
      check("amid_rst_out_b", 64'(out_b), 64'd0);
      check("amid_rst_out_mask", 64'(out_mask), 64'd0);
      check("amid_rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      idle(1);
      push(48'h014013012011, 48'h024023022021, 4'hF);
      send(8'h11, 8'h21, 1'b0);
      send(8'h12, 8'h22, 1'b0);
      send(8'h13, 8'h23, 1'b0);
      send(8'h14, 8'h24, 1'b0);
      check("fresh_out_valid", 64'(out_valid), 64'd1);
      idle(3);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
